// File: rtl/kvi_pkg.sv
// kv_initiator shared types: op/status/state encodings and width default.
// Optional timeout/abort is compiled in with KVI_TIMEOUT_EN.
package kvi_pkg;

  localparam int KW_DEF = 7;

  typedef enum logic [1:0] {
    OP_WRITE_KV   = 2'd0,
    OP_LOOKUP_KEY = 2'd1,
    OP_LOOKUP_VAL = 2'd2,
    OP_READ_IDX   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_DUP     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADARG  = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_ABORT,
    S_RESP
  } state_e;

endpackage

// File: rtl/kvi_timeout_ctr.sv
// Saturating cycle counter; expired flags the cycle that reaches LIMIT.
// Only instantiated when KVI_TIMEOUT_EN is defined.
module kvi_timeout_ctr #(
  parameter int LIMIT = 32,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != CW'(LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // fires on the enabled cycle whose count completes LIMIT
  assign expired = enable && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/kv_initiator.sv
// Host-to-store bus initiator: one strobe/ack transaction per command.
// Define KVI_TIMEOUT_EN to enable the REQ/RELEASE timeout and abort.
module kv_initiator
  import kvi_pkg::*;
#(
  parameter int KW             = KW_DEF,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [KW-1:0] cmd_key,
  input  logic [KW-1:0] cmd_val,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [KW-1:0] rsp_data,
  output logic [1:0]    rsp_status,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [3:0]    wb_sel,
  output logic [KW-1:0] wb_adr,
  output logic [KW-1:0] wb_dat,
  output logic          wb_adr_is_key,
  output logic          wb_dat_is_key,
  output logic          wb_abort,
  input  logic          wb_ack,
  input  logic          wb_dup,
  input  logic          wb_stall,
  input  logic [KW-1:0] wb_dat_i
);

  state_e        state, state_n;
  op_e           op;
  logic          bad_arg;
  logic          tmo_hit;
  logic          cyc_n, stb_n, we_n, aik_n, dik_n, abort_n;
  logic [KW-1:0] adr_n, dat_n, rdata_n;
  logic          rvalid_n;
  logic [1:0]    rstat_n;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == S_IDLE);
  assign wb_sel    = 4'hF;

  assign bad_arg = (op == OP_LOOKUP_VAL && cmd_val == '0) ||
                   (op == OP_READ_IDX   && cmd_key == '0);

`ifdef KVI_TIMEOUT_EN
  kvi_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (state == S_IDLE && cmd_valid),
    .enable  ((state == S_REQ || state == S_RELEASE) && !wb_stall),
    .expired (tmo_hit)
  );
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  logic unused_stall;
  assign unused_stall = wb_stall;
  assign tmo_hit      = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
      wb_adr        <= '0;
      wb_dat        <= '0;
      wb_adr_is_key <= 1'b0;
      wb_dat_is_key <= 1'b0;
      wb_abort      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= ST_OK;
    end else begin
      state         <= state_n;
      wb_cyc        <= cyc_n;
      wb_stb        <= stb_n;
      wb_we         <= we_n;
      wb_adr        <= adr_n;
      wb_dat        <= dat_n;
      wb_adr_is_key <= aik_n;
      wb_dat_is_key <= dik_n;
      wb_abort      <= abort_n;
      rsp_valid     <= rvalid_n;
      rsp_data      <= rdata_n;
      rsp_status    <= rstat_n;
    end
  end

  always_comb begin
    state_n  = state;
    cyc_n    = wb_cyc;
    stb_n    = wb_stb;
    we_n     = wb_we;
    adr_n    = wb_adr;
    dat_n    = wb_dat;
    aik_n    = wb_adr_is_key;
    dik_n    = wb_dat_is_key;
    abort_n  = 1'b0;
    rvalid_n = rsp_valid;
    rdata_n  = rsp_data;
    rstat_n  = rsp_status;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && bad_arg) begin
          state_n  = S_RESP;
          rvalid_n = 1'b1;
          rdata_n  = '0;
          rstat_n  = ST_BADARG;
        end else if (cmd_valid) begin
          state_n = S_REQ;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = (op == OP_WRITE_KV);
          dik_n   = 1'b0;
          unique case (op)
            OP_WRITE_KV: begin
              adr_n = cmd_key;
              dat_n = cmd_val;
              aik_n = 1'b1;
            end
            OP_LOOKUP_KEY: begin
              adr_n = cmd_key;
              dat_n = '0;
              aik_n = 1'b1;
            end
            OP_LOOKUP_VAL: begin
              adr_n = '0;
              dat_n = cmd_val;
              aik_n = 1'b0;
            end
            default: begin
              adr_n = cmd_key;
              dat_n = '0;
              aik_n = 1'b0;
            end
          endcase
        end
      end
      S_REQ: begin
        if (wb_ack) begin
          state_n = S_RELEASE;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          rdata_n = wb_dat_i;
          rstat_n = wb_dup ? ST_DUP : ST_OK;
        end else if (tmo_hit) begin
          state_n = S_ABORT;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          abort_n = 1'b1;
          rdata_n = '0;
          rstat_n = ST_TIMEOUT;
        end
      end
      S_ABORT: begin
        state_n = S_RELEASE;
      end
      S_RELEASE: begin
        // never hand back to IDLE while the responder still acks
        if (!wb_ack) begin
          state_n  = S_RESP;
          rvalid_n = 1'b1;
        end else if (tmo_hit) begin
          state_n  = S_RESP;
          rvalid_n = 1'b1;
          rdata_n  = '0;
          rstat_n  = ST_TIMEOUT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_n  = S_IDLE;
          rvalid_n = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_kv_initiator.sv
// Directed vector bench for kv_initiator with a behavioural responder.
// Timeout vectors are included when KVI_TIMEOUT_EN is defined.
module tb_kv_initiator;

  localparam int KW  = 7;
  localparam int TMO = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [KW-1:0] cmd_key = '0;
  logic [KW-1:0] cmd_val = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [KW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          wb_cyc, wb_stb, wb_we;
  logic [3:0]    wb_sel;
  logic [KW-1:0] wb_adr, wb_dat;
  logic          wb_adr_is_key, wb_dat_is_key, wb_abort;
  logic          wb_ack = 1'b0;
  logic          wb_dup = 1'b0;
  logic          wb_stall = 1'b0;
  logic [KW-1:0] wb_dat_i = '0;

  kv_initiator #(
    .KW             (KW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_key       (cmd_key),
    .cmd_val       (cmd_val),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_status    (rsp_status),
    .wb_cyc        (wb_cyc),
    .wb_stb        (wb_stb),
    .wb_we         (wb_we),
    .wb_sel        (wb_sel),
    .wb_adr        (wb_adr),
    .wb_dat        (wb_dat),
    .wb_adr_is_key (wb_adr_is_key),
    .wb_dat_is_key (wb_dat_is_key),
    .wb_abort      (wb_abort),
    .wb_ack        (wb_ack),
    .wb_dup        (wb_dup),
    .wb_stall      (wb_stall),
    .wb_dat_i      (wb_dat_i)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [KW-1:0] val;
    bit            answer;
    int            lat;
    int            hold;
    logic          dup;
    logic [KW-1:0] rdat;
    logic [KW-1:0] e_data;
    logic [1:0]    e_status;
    int            e_lat;
    int            e_rises;
    int            e_stbc;
    int            e_aborts;
    logic          e_we;
    logic [KW-1:0] e_adr;
    logic [KW-1:0] e_dat;
    logic          e_aik;
  } vec_t;

  vec_t vq[$];

  int n_cmp = 0;
  int n_err = 0;

  bit            r_answer = 1'b0;
  int            r_lat = 0;
  int            r_hold = 0;
  logic          r_dup = 1'b0;
  logic [KW-1:0] r_dat = '0;

  int            stb_rise = 0;
  int            stb_cyc = 0;
  int            abort_cyc = 0;
  int            overlap = 0;
  logic          stb_q = 1'b0;
  logic          cap_we, cap_aik, cap_dik;
  logic [KW-1:0] cap_adr, cap_dat;

  // responder: acks after r_lat strobe cycles, holds ack r_hold cycles past stb drop
  initial begin : responder
    int lat_cnt;
    int hold_cnt;
    lat_cnt  = 0;
    hold_cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (!wb_ack) begin
        if (wb_stb && r_answer) begin
          if (lat_cnt >= r_lat) begin
            wb_ack   = 1'b1;
            wb_dup   = r_dup;
            wb_dat_i = r_dat;
            hold_cnt = 0;
            lat_cnt  = 0;
          end else begin
            lat_cnt++;
          end
        end else begin
          lat_cnt = 0;
        end
      end else if (!wb_stb) begin
        if (hold_cnt >= r_hold) begin
          wb_ack   = 1'b0;
          wb_dup   = 1'b0;
          wb_dat_i = '0;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge sys_clk);
      #2;
      if (wb_stb) stb_cyc++;
      if (wb_stb && !stb_q) begin
        stb_rise++;
        cap_we  = wb_we;
        cap_adr = wb_adr;
        cap_dat = wb_dat;
        cap_aik = wb_adr_is_key;
        cap_dik = wb_dat_is_key;
      end
      stb_q = wb_stb;
      if (wb_abort) abort_cyc++;
      if (wb_stb && wb_ack) overlap++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] op, input int key, input int val,
    input bit answer, input int lat, input int hold,
    input logic dup, input int rdat,
    input int e_data, input logic [1:0] e_status, input int e_lat,
    input int e_rises, input int e_stbc, input int e_aborts,
    input logic e_we, input int e_adr, input int e_dat, input logic e_aik);
    vec_t v;
    v.op = op; v.key = KW'(key); v.val = KW'(val);
    v.answer = answer; v.lat = lat; v.hold = hold;
    v.dup = dup; v.rdat = KW'(rdat);
    v.e_data = KW'(e_data); v.e_status = e_status; v.e_lat = e_lat;
    v.e_rises = e_rises; v.e_stbc = e_stbc; v.e_aborts = e_aborts;
    v.e_we = e_we; v.e_adr = KW'(e_adr); v.e_dat = KW'(e_dat);
    v.e_aik = e_aik;
    return v;
  endfunction

  task automatic pulse_reset();
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  // called at posedge+1 with the DUT idle
  task automatic run_vec(input vec_t v, input int idx);
    int  r0, c0, a0, k;
    bit  got;
    string tag;
    tag = $sformatf("v%0d", idx);
    r_answer = v.answer; r_lat = v.lat; r_hold = v.hold;
    r_dup = v.dup; r_dat = v.rdat;
    r0 = stb_rise; c0 = stb_cyc; a0 = abort_cyc;
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_key = v.key; cmd_val = v.val;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    k = 0; got = 1'b0;
    while (!got && k < 100) begin
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge sys_clk); #1;
        k++;
      end
    end
    if (!got) begin
      chk({tag, ".rsp_wait_expired"}, 32'd1, 32'd0);
      pulse_reset();
      return;
    end
    chk({tag, ".latency"}, 32'(k), 32'(v.e_lat));
    chk({tag, ".rsp_data"}, 32'(rsp_data), 32'(v.e_data));
    chk({tag, ".rsp_status"}, 32'(rsp_status), 32'(v.e_status));
    chk({tag, ".stb_rises"}, 32'(stb_rise - r0), 32'(v.e_rises));
    chk({tag, ".stb_cycles"}, 32'(stb_cyc - c0), 32'(v.e_stbc));
    chk({tag, ".abort_cycles"}, 32'(abort_cyc - a0), 32'(v.e_aborts));
    if (v.e_rises == 1) begin
      chk({tag, ".we"}, 32'(cap_we), 32'(v.e_we));
      chk({tag, ".adr"}, 32'(cap_adr), 32'(v.e_adr));
      chk({tag, ".dat"}, 32'(cap_dat), 32'(v.e_dat));
      chk({tag, ".adr_is_key"}, 32'(cap_aik), 32'(v.e_aik));
      if (v.op == 2'd0) chk({tag, ".dat_is_key"}, 32'(cap_dik), 32'd0);
    end
    @(posedge sys_clk); #1;
    chk({tag, ".rsp_hold_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_hold_data"}, 32'(rsp_data), 32'(v.e_data));
    rsp_ready = 1'b1;
    @(posedge sys_clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin : main
    bit seen;
    vq.push_back(mk(2'd0, 5, 9, 1, 1, 0, 0, 1, 1, 2'd0, 3, 1, 2, 0, 1, 5, 9, 1));
    vq.push_back(mk(2'd1, 5, 0, 1, 0, 0, 0, 9, 9, 2'd0, 2, 1, 1, 0, 0, 5, 0, 1));
    vq.push_back(mk(2'd2, 3, 9, 1, 0, 0, 0, 5, 5, 2'd0, 2, 1, 1, 0, 0, 0, 9, 0));
    vq.push_back(mk(2'd3, 1, 4, 1, 2, 0, 0, 9, 9, 2'd0, 4, 1, 3, 0, 0, 1, 0, 0));
    vq.push_back(mk(2'd0, 5, 9, 1, 0, 0, 1, 1, 1, 2'd1, 2, 1, 1, 0, 1, 5, 9, 1));
    vq.push_back(mk(2'd2, 5, 0, 1, 0, 0, 0, 3, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(2'd1, 5, 0, 1, 0, 0, 0, 9, 9, 2'd0, 2, 1, 1, 0, 0, 5, 0, 1));
    vq.push_back(mk(2'd3, 0, 7, 1, 0, 0, 0, 3, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(2'd1, 5, 0, 1, 2, 3, 0, 9, 9, 2'd0, 7, 1, 3, 0, 0, 5, 0, 1));
    vq.push_back(mk(2'd0, 7, 3, 1, 0, 0, 0, 2, 2, 2'd0, 2, 1, 1, 0, 1, 7, 3, 1));
`ifdef KVI_TIMEOUT_EN
    vq.push_back(mk(2'd1, 6, 0, 0, 0, 0, 0, 0, 0, 2'd2, 34, 1, 32, 1, 0, 6, 0, 1));
    vq.push_back(mk(2'd1, 7, 0, 1, 0, 0, 0, 3, 3, 2'd0, 2, 1, 1, 0, 0, 7, 0, 1));
`endif

    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_data", 32'(rsp_data), 32'd0);
    chk("rst.rsp_status", 32'(rsp_status), 32'd0);
    chk("rst.wb_cyc_stb", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
    chk("rst.wb_adr_dat", 32'({wb_adr, wb_dat}), 32'd0);
    chk("rst.wb_quals", 32'({wb_adr_is_key, wb_dat_is_key, wb_abort}), 32'd0);
    chk("rst.wb_sel", 32'(wb_sel), 32'hF);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    rsp_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_ready.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_ready.cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

    // reset while a lookup is waiting in REQ
    r_answer = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_key = 7'd6; cmd_val = '0;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("midrst.stb_before", 32'(wb_stb), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midrst.stb", 32'(wb_stb), 32'd0);
    chk("midrst.cyc", 32'(wb_cyc), 32'd0);
    chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst.cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge sys_clk); #1;
      if (rsp_valid || wb_stb) seen = 1'b1;
    end
    chk("midrst.no_response", 32'(seen), 32'd0);
    chk("midrst.ready_after", 32'(cmd_ready), 32'd1);
    run_vec(mk(2'd1, 5, 0, 1, 0, 0, 0, 9, 9, 2'd0, 2, 1, 1, 0, 0, 5, 0, 1), 99);

    chk("stb_ack_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/kv_initiator.md
# kv_initiator

Bus initiator for the key/value store: accepts host commands on a valid/ready port, converts each into one single-beat strobe/acknowledge transaction toward the key/value responder, and returns read data and a status code. It sits between the host and the store, owns the STB/WE/ADR/DAT/ADR_IS_KEY/DAT_IS_KEY request lines, and recovers from non-answering lookups with a timeout and abort.

## Interface
- KW, 7: key/value/address width
- TIMEOUT_CYCLES, 32: REQ/RELEASE cycles before abort (only with KVI_TIMEOUT_EN)

- sys_clk  in  1  clock
- sys_rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0 WRITE_KV, 1 LOOKUP_KEY, 2 LOOKUP_VAL, 3 READ_IDX
- cmd_key  in  KW  key, or slot index for READ_IDX
- cmd_val  in  KW  value
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  KW  returned data
- rsp_status  out  2  0 OK, 1 DUP, 2 TIMEOUT, 3 BADARG
- wb_cyc, wb_stb, wb_we  out  1  bus request lines
- wb_sel  out  4  constant 4'hF
- wb_adr, wb_dat  out  KW  request address/data
- wb_adr_is_key, wb_dat_is_key  out  1  request qualifiers
- wb_abort  out  1  one-cycle responder FSM abort
- wb_ack, wb_dup, wb_stall  in  1  responder ACK/DUP/STALL
- wb_dat_i  in  KW  responder DAT

## Operation
- States: IDLE, REQ, RELEASE, ABORT, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register command, drive bus fields, go REQ. LOOKUP_VAL with cmd_val==0 or READ_IDX with cmd_key==0 → no bus cycle, go RESP with BADARG, rsp_data=0.
- Field mapping (held constant REQ through RELEASE):
  - WRITE_KV: we=1, adr=key, dat=val, adr_is_key=1, dat_is_key=0.
  - LOOKUP_KEY: we=0, adr=key, dat=0, adr_is_key=1.
  - LOOKUP_VAL: we=0, adr=0, dat=val, adr_is_key=0.
  - READ_IDX: we=0, adr=key, dat=0, adr_is_key=0.
- REQ: wb_cyc=wb_stb=1. On wb_ack=1: capture wb_dat_i into rsp_data; status DUP if wb_dup else OK; drop stb/cyc; go RELEASE. For WRITE_KV rsp_data is the slot index returned by the store.
- RELEASE: stb=0; wait until wb_ack=0, then RESP. A new request is never issued while wb_ack is high.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then IDLE (cmd_ready rises next cycle).
- ABORT (timeout only): wb_abort=1 for exactly one cycle, stb=0, status TIMEOUT, rsp_data=0, then RELEASE.
- wb_stall=1 in REQ: stb held, timeout counter frozen.

## Timing
- All outputs registered except cmd_ready (decoded from state).
- Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=0, all wb_* outputs 0 except wb_sel=4'hF.
- Accept at edge N → wb_stb high from N+1. wb_ack seen at edge M → stb low from M+1. rsp_valid at earliest M+2 (one RELEASE cycle with ack already low).
- BADARG: accept at N → rsp_valid at N+1, no strobe.
- Reset mid-transaction: all outputs to reset values immediately (async); pending command discarded, no response.
- rsp_ready held high in IDLE has no effect.

## Configuration
- KVI_TIMEOUT_EN defined: counter clears on entry to REQ; counts REQ and RELEASE cycles with wb_stall=0; reaching TIMEOUT_CYCLES in REQ → ABORT; in RELEASE → RESP with status TIMEOUT, no abort.
- Undefined: no counter, wb_abort tied 0, REQ/RELEASE wait indefinitely; TIMEOUT status never produced.

## Structure
- Package kvi_pkg: KW default, op enum, status enum, state enum.
- Sub-module kvi_timeout_ctr (clear, enable, expired; width $clog2(TIMEOUT_CYCLES+1)), instantiated only under KVI_TIMEOUT_EN.

## Test plan
- WRITE_KV key=5 val=9 into empty store → one strobe, we=1, adr=5, dat=9; rsp_data=1, status OK.
- LOOKUP_KEY key=5 → rsp_data=9 OK; LOOKUP_VAL val=9 → rsp_data=5 OK; READ_IDX key=1 → rsp_data=9 OK.
- LOOKUP_KEY key=6 (absent), TIMEOUT_CYCLES=32 → stb high 32 cycles, single wb_abort pulse, status TIMEOUT, next command completes normally.
- LOOKUP_VAL val=0 → rsp_valid next cycle, BADARG, wb_stb never asserted.
- Responder holds ACK 3 extra cycles after stb drop → rsp_valid only after ACK low; back-to-back command's strobe never overlaps ACK.
- sys_rst asserted during REQ → wb_stb and rsp_valid low immediately, cmd_ready=1 after release, no response for aborted command.
